// File: rtl/tone_scheduler.sv
// tone_scheduler: reduces the raw held-key bus to a single sounding note
// (last-note priority, minimum hold before preemption) and drives a ramped
// attack/sustain/release volume toward the tone generator.
module tone_scheduler #(
    parameter int TICK_DIV       = 50000,
    parameter int MIN_HOLD_TICKS = 20,
    parameter int RAMP_STEP      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keys,
    input  logic [7:0]  max_volume,
    output logic [15:0] key_out,
    output logic [7:0]  volume_out,
    output logic [3:0]  note_idx,
    output logic        busy
);
    localparam int            TW        = $clog2(TICK_DIV);
    localparam int            HW        = $clog2(MIN_HOLD_TICKS + 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MIN_HOLD_TICKS);
    localparam logic [7:0]    STEP      = 8'(RAMP_STEP);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ATTACK  = 2'd1;
    localparam logic [1:0] S_SUSTAIN = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]        state, state_n;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic              fresh;       // first cycle after reset: ignore held keys
    logic [15:0]       keys_q;
    logic [HW-1:0]     hold, hold_n;
    logic [15:0]       pend, pend_n; // one-hot pending key, 0 when empty
    logic [15:0]       key_n;
    logic [7:0]        vol_n;
    logic [15:0]       new_press, press_lo, keys_lo;
    logic              hold_done;
    logic              sw;
    logic [15:0]       sw_key;
    logic [8:0]        vol_up;
    logic signed [8:0] vol_dn;
    logic [7:0]        atk_vol, rel_vol, sus_vol;

    // Isolate the lowest set bit
    function automatic logic [15:0] lowest(input logic [15:0] v);
        return v & (~v + 16'd1);
    endfunction

    // Binary encode of a one-hot key vector (0 when empty)
    function automatic logic [3:0] enc(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    assign tick      = (tick_cnt == TICK_LAST);
    assign new_press = fresh ? 16'h0 : (keys & ~keys_q);
    assign press_lo  = lowest(new_press);
    assign keys_lo   = lowest(keys);
    assign hold_done = (hold >= HOLD_MAX);
    assign busy      = (state != S_IDLE);

    // Envelope arithmetic: 9-bit add saturating at max_volume, signed subtract
    assign vol_up  = {1'b0, volume_out} + {1'b0, STEP};
    assign vol_dn  = $signed({1'b0, volume_out}) - $signed({1'b0, STEP});
    assign atk_vol = (vol_up > {1'b0, max_volume}) ? max_volume : vol_up[7:0];
    assign rel_vol = (vol_dn < 9'sd0) ? 8'd0 : vol_dn[7:0];
    assign sus_vol = (vol_dn < $signed({1'b0, max_volume})) ? max_volume : vol_dn[7:0];

    // Envelope tick divider
    always_ff @(posedge clk) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    // Next-note selection and envelope stepping
    always_comb begin
        state_n = state;
        key_n   = key_out;
        vol_n   = volume_out;
        hold_n  = hold;
        pend_n  = pend;
        sw      = 1'b0;
        sw_key  = '0;
        case (state)
            S_IDLE: begin
                if (new_press != 16'h0) begin
                    key_n   = press_lo;
                    hold_n  = '0;
                    vol_n   = '0;
                    pend_n  = '0;
                    state_n = S_ATTACK;
                end
            end
            S_RELEASE: begin
                if (new_press != 16'h0) begin
                    key_n   = press_lo;
                    hold_n  = '0;
                    pend_n  = '0;
                    state_n = S_ATTACK;
                end else if (tick) begin
                    vol_n = rel_vol;
                    if (rel_vol == 8'd0) begin
                        state_n = S_IDLE;
                        key_n   = '0;
                    end
                end
            end
            default: begin
                if ((keys & key_out) == 16'h0) begin
                    // Current key let go: fall back immediately, min hold ignored
                    pend_n = '0;
                    if (keys == 16'h0) begin
                        state_n = S_RELEASE;
                    end else begin
                        sw = 1'b1;
                        if (new_press != 16'h0)          sw_key = press_lo;
                        else if ((pend & keys) != 16'h0) sw_key = pend;
                        else                             sw_key = keys_lo;
                    end
                end else if (new_press != 16'h0) begin
                    if (hold_done) begin
                        sw     = 1'b1;
                        sw_key = press_lo;
                        pend_n = '0;
                    end else begin
                        pend_n = press_lo;
                    end
                end else if (pend != 16'h0 && hold_done) begin
                    pend_n = '0;
                    if ((pend & keys) != 16'h0) begin
                        sw     = 1'b1;
                        sw_key = pend;
                    end
                end

                if (keys != 16'h0) begin
                    if (tick) begin
                        if (!hold_done) hold_n = hold + 1'b1;
                        if (state == S_ATTACK) begin
                            vol_n = atk_vol;
                            if (atk_vol == max_volume) state_n = S_SUSTAIN;
                        end else if (max_volume > volume_out) begin
                            state_n = S_ATTACK;
                        end else if (max_volume < volume_out) begin
                            vol_n = sus_vol;
                        end
                    end
                    // Legato switch: keep the volume, re-attack only if below target
                    if (sw) begin
                        key_n  = sw_key;
                        hold_n = '0;
                        if (vol_n < max_volume) state_n = S_ATTACK;
                    end
                end
            end
        endcase
    end

    // Scheduler state, selected note and envelope registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            key_out    <= '0;
            note_idx   <= '0;
            volume_out <= '0;
            hold       <= '0;
            pend       <= '0;
            keys_q     <= '0;
            fresh      <= 1'b1;
        end else begin
            state      <= state_n;
            key_out    <= key_n;
            note_idx   <= enc(key_n);
            volume_out <= vol_n;
            hold       <= hold_n;
            pend       <= pend_n;
            keys_q     <= keys;
            fresh      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: directed scenarios plus random key traffic,
// every cycle compared against an index/integer-based reference model.
module tb_tone_scheduler;
    localparam int TD = 4;
    localparam int MH = 2;
    localparam int RS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'hFFFF;
    logic [7:0]  maxv = 8'd245;
    logic [15:0] key_out;
    logic [7:0]  volume_out;
    logic [3:0]  note_idx;
    logic        busy;

    tone_scheduler #(.TICK_DIV(TD), .MIN_HOLD_TICKS(MH), .RAMP_STEP(RS)) dut (
        .clk(clk), .rst(rst), .keys(keys), .max_volume(maxv),
        .key_out(key_out), .volume_out(volume_out), .note_idx(note_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state 0 idle, 1 attack, 2 sustain, 3 release
    int          m_state = 0;
    int          m_note  = -1;
    int          m_vol   = 0;
    int          m_hold  = 0;
    int          m_pend  = -1;
    int          m_cyc   = 0;
    bit          m_fresh = 1'b1;
    logic [15:0] m_prev  = '0;

    function automatic int lo_idx(input logic [15:0] v);
        for (int i = 0; i < 16; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [15:0] np;
        int lnp, sw, mv;
        bit tk;
        if (rst) begin
            m_state = 0; m_note = -1; m_vol = 0; m_hold = 0; m_pend = -1;
            m_cyc = 0; m_fresh = 1'b1; m_prev = '0;
            return;
        end
        mv  = int'(maxv);
        tk  = (m_cyc % TD) == TD - 1;
        m_cyc++;
        np  = m_fresh ? 16'h0 : (keys & ~m_prev);
        m_fresh = 1'b0;
        m_prev  = keys;
        lnp = lo_idx(np);
        sw  = -1;
        case (m_state)
            0: if (lnp >= 0) begin
                m_note = lnp; m_hold = 0; m_vol = 0; m_pend = -1; m_state = 1;
            end
            3: if (lnp >= 0) begin
                m_note = lnp; m_hold = 0; m_pend = -1; m_state = 1;
            end else if (tk) begin
                m_vol = (m_vol > RS) ? m_vol - RS : 0;
                if (m_vol == 0) begin m_state = 0; m_note = -1; end
            end
            default: begin
                if (!keys[m_note]) begin
                    if (keys == 16'h0)                   m_state = 3;
                    else if (lnp >= 0)                   sw = lnp;
                    else if (m_pend >= 0 && keys[m_pend]) sw = m_pend;
                    else                                 sw = lo_idx(keys);
                    m_pend = -1;
                end else if (lnp >= 0) begin
                    if (m_hold >= MH) begin sw = lnp; m_pend = -1; end
                    else m_pend = lnp;
                end else if (m_pend >= 0 && m_hold >= MH) begin
                    if (keys[m_pend]) sw = m_pend;
                    m_pend = -1;
                end
                if (m_state != 3) begin
                    if (tk) begin
                        if (m_hold < MH) m_hold++;
                        if (m_state == 1) begin
                            m_vol = (m_vol + RS > mv) ? mv : m_vol + RS;
                            if (m_vol == mv) m_state = 2;
                        end else if (mv > m_vol) begin
                            m_state = 1;
                        end else if (mv < m_vol) begin
                            m_vol = (m_vol - RS < mv) ? mv : m_vol - RS;
                        end
                    end
                    if (sw >= 0) begin
                        m_note = sw; m_hold = 0;
                        if (m_vol < mv) m_state = 1;
                    end
                end
            end
        endcase
    endtask

    always @(posedge clk) model_step();

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("key_out",  key_out,    (m_note < 0) ? 32'd0 : (32'd1 << m_note));
        chk("volume",   volume_out, m_vol);
        chk("note_idx", note_idx,   (m_note < 0) ? 0 : m_note);
        chk("busy",     busy,       m_state != 0);
    end

    int vq[$];
    int atk_exp[4] = '{64, 128, 192, 245};
    int rel_exp[4] = '{181, 117, 53, 0};
    int sus_exp[3] = '{181, 117, 100};
    int r;
    bit sw_seen;

    task automatic trace_vol(input int ncyc);
        int last;
        vq.delete();
        last = int'(volume_out);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (int'(volume_out) != last) begin
                last = int'(volume_out);
                vq.push_back(last);
                if (last == 0) begin
                    chk("rel_key_off", key_out, 0);
                    chk("rel_idle", busy, 0);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with every key held; nothing sounds until a fresh edge
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(6);
        chk("rst_key", key_out, 0);
        chk("rst_vol", volume_out, 0);
        chk("rst_busy", busy, 0);
        keys = 16'hFFFE;
        @(negedge clk);
        keys = 16'hFFFF;
        @(negedge clk);
        chk("key0_press", key_out, 16'h0001);
        keys = 16'h0;
        wait_idle();

        // Attack then release on key 3
        keys = 16'h0008;
        trace_vol(20);
        chk("atk_len", vq.size(), 4);
        foreach (atk_exp[i]) chk("atk_vol", (i < vq.size()) ? vq[i] : -1, atk_exp[i]);
        chk("note3", note_idx, 3);
        keys = 16'h0;
        trace_vol(24);
        chk("rel_len", vq.size(), 4);
        foreach (rel_exp[i]) chk("rel_vol", (i < vq.size()) ? vq[i] : -1, rel_exp[i]);
        wait_idle();

        // Minimum hold: key 7 pressed one tick into key 2
        keys = 16'h0004;
        for (int i = 0; i < 10 && volume_out == 0; i++) @(negedge clk);
        keys = 16'h0084;
        @(negedge clk);
        chk("no_preempt", key_out, 16'h0004);
        sw_seen = 1'b0;
        for (int i = 0; i < 12 && !sw_seen; i++) begin
            @(negedge clk);
            chk("legato", volume_out != 0, 1);
            if (key_out == 16'h0080) sw_seen = 1'b1;
            else chk("hold_key", key_out, 16'h0004);
        end
        chk("preempt", key_out, 16'h0080);
        chk("preempt_idx", note_idx, 7);
        keys = 16'h0;
        wait_idle();

        // Simultaneous presses: lowest index wins
        keys = 16'h0120;
        @(negedge clk);
        chk("simul_idx", note_idx, 5);
        keys = 16'h0;
        wait_idle();

        // Fallback to still-held key 1 after key 9 is released
        keys = 16'h0002;
        wait_cyc(20);
        keys = 16'h0202;
        @(negedge clk);
        chk("key9", key_out, 16'h0200);
        wait_cyc(12);
        keys = 16'h0002;
        @(negedge clk);
        chk("fallback", key_out, 16'h0002);
        wait_cyc(8);
        chk("fb_vol", volume_out, 245);
        chk("fb_busy", busy, 1);

        // Lower the sustain target, then reset mid-note
        maxv = 8'd100;
        trace_vol(16);
        chk("sus_len", vq.size(), 3);
        foreach (sus_exp[i]) chk("sus_vol", (i < vq.size()) ? vq[i] : -1, sus_exp[i]);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_key", key_out, 0);
        chk("mid_rst_vol", volume_out, 0);
        chk("mid_rst_idx", note_idx, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        keys = 16'h0;
        maxv = 8'd0;
        wait_cyc(2);

        // Zero target volume: attack settles straight into sustain at 0
        keys = 16'h0001;
        wait_cyc(8);
        chk("zero_vol", volume_out, 0);
        chk("zero_busy", busy, 1);
        keys = 16'h0;
        wait_idle();
        maxv = 8'd245;

        // Random key traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 12)      keys = keys ^ (16'h1 << $urandom_range(0, 5));
            else if (r < 14) keys = keys ^ (16'h1 << $urandom_range(6, 15));
            else if (r < 15) keys = 16'h0;
            if ($urandom_range(0, 149) == 0) maxv = 8'($urandom_range(0, 255));
        end
        rst = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
- Sits between the raw 16-bit piano key bus and the tone generator.
- Reduces any set of held keys to a single one-hot note using last-note priority with a minimum note hold time.
- Drives a ramped volume (attack, sustain, release) so the amplifier never sees abrupt steps.
- Its key_out/volume_out feed the tone generator's keys/volume inputs directly.

Parameters:
- TICK_DIV, 50000: clk cycles per envelope tick (1 ms at 50 MHz); legal range ≥2.
- MIN_HOLD_TICKS, 20: ticks a note must sound before a new press may preempt it.
- RAMP_STEP, 8: volume change per tick during attack and release.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- keys  in  16  raw held-key bus, bit i = key i pressed
- max_volume  in  8  target sustain volume
- key_out  out  16  one-hot selected key, or 0 when silent
- volume_out  out  8  ramped volume to the tone generator
- note_idx  out  4  binary index of key_out bit (0 when silent)
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: rst sampled at posedge. key_out=0, volume_out=0, note_idx=0, busy=0, state=IDLE. Tick counter, hold counter, pending register and keys_q are all cleared. rst mid-note silences on the next edge with no release ramp.
- Tick: a counter counts 0..TICK_DIV-1. tick=1 for one cycle when the counter equals TICK_DIV-1. Volume and hold counter change only on tick cycles.
- Edge detect: keys_q is keys registered each cycle. new_press = keys & ~keys_q. When several new presses occur in one cycle, the lowest index wins.
- Latency: a key change sampled at edge N is reflected in key_out/note_idx at edge N+1.
- States: IDLE, ATTACK, SUSTAIN, RELEASE.
- IDLE:
  - A new press loads key_out and sets the hold counter to 0; go to ATTACK with volume_out=0.
  - If keys are held at reset exit, nothing happens until a fresh rising edge.
- ATTACK: each tick, volume_out = min(volume_out+RAMP_STEP, max_volume). When volume_out equals max_volume, go to SUSTAIN.
- SUSTAIN:
  - Each tick, if max_volume > volume_out, go back to ATTACK.
  - If max_volume < volume_out, volume_out = max(volume_out-RAMP_STEP, max_volume) and stay in SUSTAIN.
- Preemption (ATTACK/SUSTAIN):
  - The hold counter increments per tick and saturates at MIN_HOLD_TICKS.
  - A new press with hold ≥ MIN_HOLD_TICKS switches key_out immediately and resets the hold counter.
  - volume_out is kept (legato); the state goes to ATTACK if volume_out < max_volume.
  - A new press with hold < MIN_HOLD_TICKS is latched into the single pending slot; a later press overwrites it.
  - When hold reaches MIN_HOLD_TICKS, the pending key takes over if still held, otherwise it is dropped. The pending slot is cleared either way.
- Release of current key while other keys are held:
  - Switch immediately, ignoring min hold, to the pending key if still held, else the lowest-index held key.
  - Reset the hold counter and clear pending.
- All keys released (ATTACK/SUSTAIN): go to RELEASE. key_out is retained and pending is cleared.
- RELEASE:
  - Each tick, volume_out = max(volume_out-RAMP_STEP, 0).
  - On reaching 0: state=IDLE and key_out=0 on the same edge.
  - A new press in RELEASE loads the new key, resets hold and goes to ATTACK from the current volume_out.
- Simultaneous events in one cycle: rst beats everything. A new press beats an all-released condition. Key switching and the tick volume update may coincide; both apply.
- Arithmetic: 9-bit intermediate for the add, saturate to max_volume. Signed compare for the subtract, floor at 0. max_volume=0 in IDLE with a press: go to ATTACK, then SUSTAIN on the first tick at volume 0.
- note_idx is the binary encode of key_out and is registered with it.

Test Plan:
(Bench parameters: TICK_DIV=4, MIN_HOLD_TICKS=2, RAMP_STEP=64, max_volume=245.)
- Reset: hold rst 3 cycles with keys=16'hFFFF, then release rst. Required: key_out=0, volume_out=0, busy=0 with no activity. Then toggle key 0: key_out=16'h0001 one cycle after the edge.
- Attack/release: press key 3 only. Required: note_idx=3 and volume_out 64,128,192,245 on successive ticks, then SUSTAIN. Release key 3: volume_out 181,117,53,0, then key_out=0 and busy=0 on the same edge.
- Min hold: press key 2, then press key 7 one tick later. Required: key_out stays 16'h0004 until the hold counter reaches 2, then becomes 16'h0080, with volume_out continuous and not reset to 0.
- Simultaneous press: from IDLE, keys=16'h0120 in one cycle. Required: note_idx=5.
- Fallback on release: hold keys 1 and 9 with 9 sounding past min hold, then release key 9. Required: key_out=16'h0002 next cycle, state stays in SUSTAIN.
- Volume and mid-note reset: in SUSTAIN at 245, drop max_volume to 100. Required: volume_out 181, then 117, then 100. Then assert rst mid-note: all outputs 0 on the next edge.
